psa_ctrl: RTL and testbench
===========================

// Module: psa_ctrl
// PURPOSE
//  Z80 I/O-mapped bridge between the host CPU and the sound board: decodes I/O cycles,
//  latches an 11-bit address and 8-bit data for a 2Kx8 sample RAM and generates the RAM strobes.
//  Also selects the timer chip (ports 0x0C-0x0F), the system read buffer (all other reads),
//  the timer gates and the LEDs.
// PARAMETERS
//  none (widths fixed: ZA 8, ZD 8, CA/FA 11, CD 8)
// PORTS
//  i_CLK         in   1   system clock; rising edge
//  i_nRST        in   1   asynchronous active-low reset
//  i_PON         in   1   power-on good; 0 = held in reset, same as i_nRST=0
//  i_nIORQ       in   1   Z80 I/O request, active low
//  i_nRD         in   1   Z80 read strobe, active low
//  i_nWR         in   1   Z80 write strobe, active low
//  i_ZA          in   8   Z80 I/O address A[7:0]
//  i_ZD          in   8   Z80 data bus, write data
//  i_FA          in   11  ROM fetch address from the playback side
//  i_DIPSW       in   4   board DIP switches
//  o_nSYSTEM_RD  out  1   system read buffer enable, active low
//  o_nTIMER_CS   out  1   timer chip select, active low
//  o_TIMER_GATE  out  3   timer gate lines
//  o_nRAM_CS     out  1   sample RAM chip select, active low
//  o_nRAM_WR     out  1   sample RAM write enable, active low
//  o_nROM_CS     out  1   sample ROM chip select, active low
//  o_CA          out  11  RAM/ROM address
//  o_CD          out  8   RAM write data
//  o_nLED        out  2   LEDs, active low
// BEHAVIOUR
//  - rst = !i_nRST | !i_PON, asynchronous. Registers: DATA=0, ADDR=0, CTRL=0, GATE=i_DIPSW[2:0].
//  - Definitions: rd = !nIORQ & !nRD; wr = !nIORQ & !nWR.
//  - Reads (combinational, no latency):
//    ZA in 0x0C..0x0F -> nTIMER_CS=0, nSYSTEM_RD=1.
//    Any other ZA -> nSYSTEM_RD=0, nTIMER_CS=1.
//    No read cycle -> both outputs = 1.
//  - Write registers, loaded on each rising i_CLK while wr and ZA matches:
//    0x00 DATA (->CD)
//    0x01 ADDR[7:0]
//    0x02 CTRL: [2:0]=ADDR[10:8], [4]=RAM write command, [5]=ROM mode
//    0x03 GATE[2:0] -> o_TIMER_GATE; [5:4] -> LED register
//    Other ports are ignored.
//  - Bypass: during a wr cycle to 0x02, the CA[10:8] and command bits are taken directly from ZD.
//    Outputs are therefore valid in the same cycle, before any clock edge.
//  - RAM write strobe: nRAM_CS = nRAM_WR = 0 exactly while (wr & ZA==0x02 & ZD[4]).
//    Both return to 1 combinationally when nIORQ or nWR rises.
//  - The CA and CD values stay latched after the cycle.
//    Example: 0x00<-0xCD, 0x01<-0xAD, 0x02<-0x17 gives CA=0x7AD, CD=0xCD.
//  - ROM mode (CTRL[5]=1): nROM_CS=0 and CA=i_FA. Otherwise nROM_CS=1 and CA={CTRL[2:0],ADDR}.
//  - A RAM write strobe always forces the RAM address path and nROM_CS=1.
//  - Reset in mid-cycle: strobes deassert at once and the registers clear.
//  - Reset values of outputs: nSYSTEM_RD=1, nTIMER_CS=1, nRAM_CS=1, nRAM_WR=1, nROM_CS=1,
//    CA=0, CD=0, nLED=2'b11, TIMER_GATE=i_DIPSW[2:0]. i_DIPSW[3] is reserved.
// CONFIGURATION
//  - PSA_LED_ACTIVITY_EN defined:
//    nLED[0] is low while a RAM write strobe is active.
//    nLED[1] is low while nTIMER_CS=0.
//  - Not defined: nLED = ~LED register, written from port 0x03 [5:4].
// STRUCTURE
//  - Package psa_pkg: port constants P_DATA=0x00, P_ADDR=0x01, P_CTRL=0x02, P_GATE=0x03,
//    P_TIMER_LO=0x0C, P_TIMER_HI=0x0F; CTRL bit positions; width constants.
//  - One sub-module, psa_io_decode: combinational rd/wr/port-match decode and chip selects.
//  - Registers, bypass mux and output muxing stay in the top level.
// TESTING
//  - Read ZA=0x0C, 0x0F -> nTIMER_CS=0, nSYSTEM_RD=1.
//    Read ZA=0x00, 0x10 -> nSYSTEM_RD=0, nTIMER_CS=1.
//  - Write 0x00<-0xCD, 0x01<-0xAD, 0x02<-0x17.
//    Mid-cycle: nRAM_CS=0, nRAM_WR=0, nROM_CS=1, CA=0x7AD, CD=0xCD.
//    After the cycle: nRAM_CS=nRAM_WR=1, CA and CD unchanged.
//  - Pulse i_nRST low, then repeat the previous sequence three times -> identical results each time.
//    Check CA=0, CD=0 after each reset.
//  - Write 0x02<-0x20 with FA=0x123 -> nROM_CS=0, CA=0x123, nRAM_CS=1.
//  - Write 0x03<-0x05 -> TIMER_GATE=3'b101.
//    Without the macro: 0x03<-0x10 -> nLED=2'b10.
//  - Hold i_PON=0 -> all outputs at their reset values; bus writes are ignored.

Source files
------------

// File: rtl/psa_pkg.sv
// Shared constants for the psa_ctrl Z80 sound-board bridge: port map, CTRL/GATE
// field positions and bus widths.
package psa_pkg;

  localparam int unsigned ZA_W = 8;
  localparam int unsigned ZD_W = 8;
  localparam int unsigned CA_W = 11;
  localparam int unsigned CD_W = 8;

  localparam logic [ZA_W-1:0] P_DATA     = 8'h00;
  localparam logic [ZA_W-1:0] P_ADDR     = 8'h01;
  localparam logic [ZA_W-1:0] P_CTRL     = 8'h02;
  localparam logic [ZA_W-1:0] P_GATE     = 8'h03;
  localparam logic [ZA_W-1:0] P_TIMER_LO = 8'h0C;
  localparam logic [ZA_W-1:0] P_TIMER_HI = 8'h0F;

  localparam int unsigned CTRL_AHI_MSB = 2;
  localparam int unsigned CTRL_RAMWR   = 4;
  localparam int unsigned CTRL_ROM     = 5;
  localparam int unsigned GATE_MSB     = 2;
  localparam int unsigned GATE_LED_LSB = 4;
  localparam int unsigned GATE_LED_MSB = 5;

  typedef struct packed {
    logic       rom;
    logic [2:0] addr_hi;
  } ctrl_t;

  function automatic logic is_timer_port(input logic [ZA_W-1:0] za);
    return (za >= P_TIMER_LO) && (za <= P_TIMER_HI);
  endfunction

endpackage

// File: rtl/psa_io_decode.sv
// Combinational Z80 I/O cycle decode: read/write qualification, write-port matches
// and the timer / system-read chip selects. i_en low (reset) forces everything idle.
module psa_io_decode
  import psa_pkg::*;
(
  input  logic            i_en,
  input  logic            i_nIORQ,
  input  logic            i_nRD,
  input  logic            i_nWR,
  input  logic [ZA_W-1:0] i_ZA,
  output logic            o_wr_data,
  output logic            o_wr_addr,
  output logic            o_wr_ctrl,
  output logic            o_wr_gate,
  output logic            o_nTIMER_CS,
  output logic            o_nSYSTEM_RD
);

  logic w_rd;
  logic w_wr;
  logic w_timer;

  assign w_rd    = i_en & ~i_nIORQ & ~i_nRD;
  assign w_wr    = i_en & ~i_nIORQ & ~i_nWR;
  assign w_timer = is_timer_port(i_ZA);

  assign o_wr_data = w_wr & (i_ZA == P_DATA);
  assign o_wr_addr = w_wr & (i_ZA == P_ADDR);
  assign o_wr_ctrl = w_wr & (i_ZA == P_CTRL);
  assign o_wr_gate = w_wr & (i_ZA == P_GATE);

  assign o_nTIMER_CS  = ~(w_rd &  w_timer);
  assign o_nSYSTEM_RD = ~(w_rd & ~w_timer);

endmodule

// File: rtl/psa_ctrl.sv
// Z80 I/O bridge to the sound board: sample RAM address/data latches, RAM/ROM strobes,
// timer gates and LEDs. Define PSA_LED_ACTIVITY_EN to drive the LEDs from bus activity.
module psa_ctrl
  import psa_pkg::*;
(
  input  logic            i_CLK,
  input  logic            i_nRST,
  input  logic            i_PON,
  input  logic            i_nIORQ,
  input  logic            i_nRD,
  input  logic            i_nWR,
  input  logic [ZA_W-1:0] i_ZA,
  input  logic [ZD_W-1:0] i_ZD,
  input  logic [CA_W-1:0] i_FA,
  input  logic [3:0]      i_DIPSW,
  output logic            o_nSYSTEM_RD,
  output logic            o_nTIMER_CS,
  output logic [2:0]      o_TIMER_GATE,
  output logic            o_nRAM_CS,
  output logic            o_nRAM_WR,
  output logic            o_nROM_CS,
  output logic [CA_W-1:0] o_CA,
  output logic [CD_W-1:0] o_CD,
  output logic [1:0]      o_nLED
);

  logic            w_rst_n;
  logic            w_wr_data;
  logic            w_wr_addr;
  logic            w_wr_ctrl;
  logic            w_wr_gate;
  logic            w_strobe;
  logic            w_rom;
  logic            w_rom_sel;
  logic [2:0]      w_addr_hi;
  logic            w_unused_dipsw;

  logic [CD_W-1:0] r_data;
  logic [7:0]      r_addr;
  ctrl_t           r_ctrl;
  logic [2:0]      r_gate;
  logic            r_gate_vld;

  assign w_rst_n        = i_nRST & i_PON;
  assign w_unused_dipsw = i_DIPSW[3];

  psa_io_decode u_decode (
    .i_en         (w_rst_n),
    .i_nIORQ      (i_nIORQ),
    .i_nRD        (i_nRD),
    .i_nWR        (i_nWR),
    .i_ZA         (i_ZA),
    .o_wr_data    (w_wr_data),
    .o_wr_addr    (w_wr_addr),
    .o_wr_ctrl    (w_wr_ctrl),
    .o_wr_gate    (w_wr_gate),
    .o_nTIMER_CS  (o_nTIMER_CS),
    .o_nSYSTEM_RD (o_nSYSTEM_RD)
  );

  // Gate tracks the DIP switches until the host first writes it, so reset needs no
  // data-dependent async load.
  always_ff @(posedge i_CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_data     <= '0;
      r_addr     <= '0;
      r_ctrl     <= '0;
      r_gate     <= '0;
      r_gate_vld <= 1'b0;
    end else begin
      if (w_wr_data) r_data <= i_ZD;
      if (w_wr_addr) r_addr <= i_ZD;
      if (w_wr_ctrl) begin
        r_ctrl.addr_hi <= i_ZD[CTRL_AHI_MSB:0];
        r_ctrl.rom     <= i_ZD[CTRL_ROM];
      end
      if (w_wr_gate) begin
        r_gate     <= i_ZD[GATE_MSB:0];
        r_gate_vld <= 1'b1;
      end
    end
  end

  // CTRL write cycle bypasses the register so CA and strobes are valid before the edge.
  assign w_strobe  = w_wr_ctrl & i_ZD[CTRL_RAMWR];
  assign w_addr_hi = w_wr_ctrl ? i_ZD[CTRL_AHI_MSB:0] : r_ctrl.addr_hi;
  assign w_rom     = w_wr_ctrl ? i_ZD[CTRL_ROM] : r_ctrl.rom;
  assign w_rom_sel = w_rom & ~w_strobe;

  always_comb begin
    o_CA      = {w_addr_hi, r_addr};
    o_nROM_CS = 1'b1;
    if (w_rom_sel) begin
      o_CA      = i_FA;
      o_nROM_CS = 1'b0;
    end
  end

  assign o_nRAM_CS    = ~w_strobe;
  assign o_nRAM_WR    = ~w_strobe;
  assign o_CD         = r_data;
  assign o_TIMER_GATE = r_gate_vld ? r_gate : i_DIPSW[2:0];

`ifdef PSA_LED_ACTIVITY_EN
  assign o_nLED = {o_nTIMER_CS, ~w_strobe};
`else
  logic [1:0] r_led;

  always_ff @(posedge i_CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_led <= '0;
    end else if (w_wr_gate) begin
      r_led <= i_ZD[GATE_LED_MSB:GATE_LED_LSB];
    end
  end

  assign o_nLED = ~r_led;
`endif

endmodule

// File: tb/tb_psa_ctrl.sv
// Directed self-checking bench for psa_ctrl: decode, latches, strobes, ROM mode,
// gates/LEDs, reset and power-on hold.
module tb_psa_ctrl;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        pon = 1'b1;
  logic        niorq = 1'b1;
  logic        nrd = 1'b1;
  logic        nwr = 1'b1;
  logic [7:0]  za = '0;
  logic [7:0]  zd = '0;
  logic [10:0] fa = '0;
  logic [3:0]  dipsw = 4'b1110;

  logic        nsys_rd;
  logic        ntimer_cs;
  logic [2:0]  timer_gate;
  logic        nram_cs;
  logic        nram_wr;
  logic        nrom_cs;
  logic [10:0] ca;
  logic [7:0]  cd;
  logic [1:0]  nled;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  psa_ctrl dut (
    .i_CLK        (clk),
    .i_nRST       (nrst),
    .i_PON        (pon),
    .i_nIORQ      (niorq),
    .i_nRD        (nrd),
    .i_nWR        (nwr),
    .i_ZA         (za),
    .i_ZD         (zd),
    .i_FA         (fa),
    .i_DIPSW      (dipsw),
    .o_nSYSTEM_RD (nsys_rd),
    .o_nTIMER_CS  (ntimer_cs),
    .o_TIMER_GATE (timer_gate),
    .o_nRAM_CS    (nram_cs),
    .o_nRAM_WR    (nram_wr),
    .o_nROM_CS    (nrom_cs),
    .o_CA         (ca),
    .o_CD         (cd),
    .o_nLED       (nled)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Drives a write and leaves it open just past the rising edge for mid-cycle checks.
  task automatic wr_begin(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    za = a; zd = d; niorq = 1'b0; nwr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_end();
    @(negedge clk);
    niorq = 1'b1; nwr = 1'b1; nrd = 1'b1;
    #1;
  endtask

  task automatic rd_begin(input logic [7:0] a);
    @(negedge clk);
    za = a; niorq = 1'b0; nrd = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    #3;
    nrst = 1'b1;
    #1;
  endtask

  task automatic ram_sequence(input string pfx);
    wr_begin(8'h00, 8'hCD); bus_end();
    wr_begin(8'h01, 8'hAD); bus_end();
    wr_begin(8'h02, 8'h17);
    check({pfx, "_mid_nram_cs"}, nram_cs, 1'b0);
    check({pfx, "_mid_nram_wr"}, nram_wr, 1'b0);
    check({pfx, "_mid_nrom_cs"}, nrom_cs, 1'b1);
    check({pfx, "_mid_ca"}, ca, 11'h7AD);
    check({pfx, "_mid_cd"}, cd, 8'hCD);
    bus_end();
    check({pfx, "_post_nram_cs"}, nram_cs, 1'b1);
    check({pfx, "_post_nram_wr"}, nram_wr, 1'b1);
    check({pfx, "_post_ca"}, ca, 11'h7AD);
    check({pfx, "_post_cd"}, cd, 8'hCD);
  endtask

  initial begin
    #2;
    check("rst_nsys_rd", nsys_rd, 1'b1);
    check("rst_ntimer", ntimer_cs, 1'b1);
    check("rst_nram_cs", nram_cs, 1'b1);
    check("rst_nram_wr", nram_wr, 1'b1);
    check("rst_nrom_cs", nrom_cs, 1'b1);
    check("rst_ca", ca, 11'h000);
    check("rst_cd", cd, 8'h00);
    check("rst_nled", nled, 2'b11);
    check("rst_gate", timer_gate, 3'b110);
    #10;
    nrst = 1'b1;
    #1;

    rd_begin(8'h0C);
    check("rd0C_ntimer", ntimer_cs, 1'b0);
    check("rd0C_nsys", nsys_rd, 1'b1);
`ifdef PSA_LED_ACTIVITY_EN
    check("rd0C_nled", nled, 2'b01);
`endif
    bus_end();
    check("idle_ntimer", ntimer_cs, 1'b1);
    check("idle_nsys", nsys_rd, 1'b1);
    rd_begin(8'h0F);
    check("rd0F_ntimer", ntimer_cs, 1'b0);
    check("rd0F_nsys", nsys_rd, 1'b1);
    bus_end();
    rd_begin(8'h00);
    check("rd00_nsys", nsys_rd, 1'b0);
    check("rd00_ntimer", ntimer_cs, 1'b1);
    bus_end();
    rd_begin(8'h10);
    check("rd10_nsys", nsys_rd, 1'b0);
    check("rd10_ntimer", ntimer_cs, 1'b1);
    bus_end();
    rd_begin(8'h0B);
    check("rd0B_nsys", nsys_rd, 1'b0);
    check("rd0B_ntimer", ntimer_cs, 1'b1);
    bus_end();

    ram_sequence("seq0");
    for (int i = 1; i <= 3; i++) begin
      do_reset();
      check($sformatf("rst%0d_ca", i), ca, 11'h000);
      check($sformatf("rst%0d_cd", i), cd, 8'h00);
      ram_sequence($sformatf("seq%0d", i));
    end

    // Reset asserted in the middle of a strobed write.
    wr_begin(8'h02, 8'h17);
`ifdef PSA_LED_ACTIVITY_EN
    check("strobe_nled0", nled, 2'b10);
`endif
    nrst = 1'b0;
    #1;
    check("midrst_nram_cs", nram_cs, 1'b1);
    check("midrst_nram_wr", nram_wr, 1'b1);
    check("midrst_ca", ca, 11'h000);
    check("midrst_cd", cd, 8'h00);
    nrst = 1'b1;
    bus_end();

    ram_sequence("seq4");
    fa = 11'h123;
    wr_begin(8'h02, 8'h20);
    check("rom_mid_nrom", nrom_cs, 1'b0);
    check("rom_mid_ca", ca, 11'h123);
    check("rom_mid_nram", nram_cs, 1'b1);
    bus_end();
    check("rom_post_nrom", nrom_cs, 1'b0);
    check("rom_post_ca", ca, 11'h123);
    wr_begin(8'h02, 8'h30);
    check("romwr_nram", nram_cs, 1'b0);
    check("romwr_nrom", nrom_cs, 1'b1);
    check("romwr_ca", ca, 11'h0AD);
    bus_end();
    check("romwr_post_ca", ca, 11'h123);
    wr_begin(8'h02, 8'h05); bus_end();
    check("ramaddr_nrom", nrom_cs, 1'b1);
    check("ramaddr_ca", ca, 11'h5AD);

    wr_begin(8'h07, 8'h99); bus_end();
    check("ign_cd", cd, 8'hCD);
    check("ign_ca", ca, 11'h5AD);

    check("gate_dip", timer_gate, 3'b110);
    wr_begin(8'h03, 8'h05); bus_end();
    check("gate_101", timer_gate, 3'b101);
    dipsw = 4'b0011;
    #1;
    check("gate_hold", timer_gate, 3'b101);
`ifndef PSA_LED_ACTIVITY_EN
    check("led_00", nled, 2'b11);
`endif
    wr_begin(8'h03, 8'h10); bus_end();
    check("gate_000", timer_gate, 3'b000);
`ifndef PSA_LED_ACTIVITY_EN
    check("led_10", nled, 2'b10);
`endif

    // Power-on hold: everything at reset values and bus cycles have no effect.
    pon = 1'b0;
    #1;
    check("pon_gate", timer_gate, 3'b011);
    check("pon_nled", nled, 2'b11);
    wr_begin(8'h00, 8'h55); bus_end();
    wr_begin(8'h02, 8'h17);
    check("pon_nram_cs", nram_cs, 1'b1);
    check("pon_nram_wr", nram_wr, 1'b1);
    check("pon_ca", ca, 11'h000);
    check("pon_cd", cd, 8'h00);
    check("pon_nrom", nrom_cs, 1'b1);
    bus_end();
    rd_begin(8'h0C);
    check("pon_ntimer", ntimer_cs, 1'b1);
    check("pon_nsys", nsys_rd, 1'b1);
    bus_end();
    pon = 1'b1;
    #1;
    check("pon_rel_cd", cd, 8'h00);
    check("pon_rel_ca", ca, 11'h000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
